// File: rtl/ar4_host_pkg.sv
// Shared types and constants for the AR4 host sequencer.
package ar4_host_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START     = 4'd1,
        S_GAP     = 4'd2,
        A_SETUP   = 4'd3,
        A_PULSE   = 4'd4,
        A_GAP     = 4'd5,
        X_SETUP   = 4'd6,
        X_PULSE   = 4'd7,
        X_GAP     = 4'd8,
        WAIT_LOW  = 4'd9,
        WAIT_HIGH = 4'd10,
        PUT       = 4'd11,
        FIN       = 4'd12
    } ar4_state_e;

    // Number of bus bytes needed to carry an n-bit operand.
    function automatic int byte_count(input int n);
        return n / BYTE_W;
    endfunction

endpackage

// File: rtl/ar4_host_sequencer_if.sv
// Request/byte-bus bundle between the host sequencer and its environment.
// The master side is the sequencer itself; the slave side issues requests,
// provides the multiplier ready level and observes the strobes.
interface ar4_host_sequencer_if #(
    parameter int N = 16
);
    logic         go;
    logic [N-1:0] opA;
    logic [N-1:0] opX;
    logic         readyAR4;
    logic [7:0]   inBus;
    logic         startAR4;
    logic         getA;
    logic         getX;
    logic         putOut;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        input  go, opA, opX, readyAR4,
        output inBus, startAR4, getA, getX, putOut, busy, done, err
    );

    modport slave (
        output go, opA, opX, readyAR4,
        input  inBus, startAR4, getA, getX, putOut, busy, done, err
    );
endinterface

// File: rtl/ar4_strobe_timer.sv
// Loadable down-counter with a terminal-count flag. Loading L-1 on state
// entry makes the state last exactly L cycles: tc is high in the last one.
module ar4_strobe_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/ar4_host_sequencer.sv
// Host-side driver for the radix-4 multiplier byte-bus loader: issues the
// start strobe, streams A then X LSB-byte-first under getA/getX, waits for
// the ready low/high handshake (with timeout) and pulses putOut.
// All outputs are registered from the next-state decode.
module ar4_host_sequencer
    import ar4_host_pkg::*;
#(
    parameter int N         = 16,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 1,
    parameter int PUT_LEN   = 10,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    ar4_host_sequencer_if.master bus
);
    localparam int B     = byte_count(N);
    localparam int IW    = (B > 1) ? $clog2(B) : 1;
    localparam int T_PG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int T_PT  = (PUT_LEN > TIMEOUT) ? PUT_LEN : TIMEOUT;
    localparam int T_MAX = (T_PG > T_PT) ? T_PG : T_PT;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_PULSE = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] LD_GAP   = TW'(GAP_LEN - 1);
    localparam logic [TW-1:0] LD_PUT   = TW'(PUT_LEN - 1);
    localparam logic [TW-1:0] LD_TO    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(B - 1);

    ar4_state_e    state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  x_q, x_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          to_s;

    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_tc_s;

    logic [7:0]    a_byte_s, x_byte_s;

    logic [7:0]    inbus_q, inbus_d;
    logic          start_q, start_d;
    logic          geta_q, geta_d;
    logic          getx_q, getx_d;
    logic          put_q, put_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Next-state, operand capture and byte index sequencing.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        idx_d   = idx_q;
        to_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    a_d     = bus.opA;
                    x_d     = bus.opX;
                    idx_d   = {IW{1'b0}};
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tmr_tc_s) state_d = S_GAP;
                else          state_d = START;
            end
            S_GAP: begin
                if (tmr_tc_s) state_d = A_SETUP;
                else          state_d = S_GAP;
            end
            A_SETUP: state_d = A_PULSE;
            A_PULSE: begin
                if (tmr_tc_s) state_d = A_GAP;
                else          state_d = A_PULSE;
            end
            A_GAP: begin
                if (!tmr_tc_s) begin
                    state_d = A_GAP;
                end else if (idx_q == IDX_LAST) begin
                    idx_d   = {IW{1'b0}};
                    state_d = X_SETUP;
                end else begin
                    idx_d   = idx_q + IW'(1'b1);
                    state_d = A_SETUP;
                end
            end
            X_SETUP: state_d = X_PULSE;
            X_PULSE: begin
                if (tmr_tc_s) state_d = X_GAP;
                else          state_d = X_PULSE;
            end
            X_GAP: begin
                if (!tmr_tc_s) begin
                    state_d = X_GAP;
                end else if (idx_q == IDX_LAST) begin
                    idx_d   = {IW{1'b0}};
                    state_d = WAIT_LOW;
                end else begin
                    idx_d   = idx_q + IW'(1'b1);
                    state_d = X_SETUP;
                end
            end
            WAIT_LOW: begin
                // An awaited level in the last allowed cycle still counts.
                if (!bus.readyAR4) begin
                    state_d = WAIT_HIGH;
                end else if (tmr_tc_s) begin
                    to_s    = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (bus.readyAR4) begin
                    state_d = PUT;
                end else if (tmr_tc_s) begin
                    to_s    = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            PUT: begin
                if (tmr_tc_s) state_d = FIN;
                else          state_d = PUT;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer reload on every state change, with the length of the new state.
    always_comb begin
        tmr_load_s = (state_d != state_q);
        case (state_d)
            START, A_PULSE, X_PULSE: tmr_val_s = LD_PULSE;
            S_GAP, A_GAP, X_GAP:     tmr_val_s = LD_GAP;
            PUT:                     tmr_val_s = LD_PUT;
            WAIT_LOW, WAIT_HIGH:     tmr_val_s = LD_TO;
            default:                 tmr_val_s = {TW{1'b0}};
        endcase
    end

    ar4_strobe_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    // Byte select of both shadow operands at the upcoming byte index.
    always_comb begin
        a_byte_s = 8'h00;
        x_byte_s = 8'h00;
        for (int i = 0; i < B; i++) begin
            a_byte_s = a_byte_s | ((idx_d == IW'(i)) ? a_q[i*BYTE_W +: BYTE_W] : 8'h00);
            x_byte_s = x_byte_s | ((idx_d == IW'(i)) ? x_q[i*BYTE_W +: BYTE_W] : 8'h00);
        end
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        case (state_d)
            A_SETUP: inbus_d = a_byte_s;
            X_SETUP: inbus_d = x_byte_s;
            FIN:     inbus_d = 8'h00;
            default: inbus_d = inbus_q;
        endcase
        start_d = (state_d != START);
        geta_d  = (state_d != A_PULSE);
        getx_d  = (state_d != X_PULSE);
        put_d   = (state_d != PUT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        err_d   = to_s;
    end

    // State, shadow operands, byte index and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {N{1'b0}};
            x_q     <= {N{1'b0}};
            idx_q   <= {IW{1'b0}};
            inbus_q <= 8'h00;
            start_q <= 1'b1;
            geta_q  <= 1'b1;
            getx_q  <= 1'b1;
            put_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            idx_q   <= idx_d;
            inbus_q <= inbus_d;
            start_q <= start_d;
            geta_q  <= geta_d;
            getx_q  <= getx_d;
            put_q   <= put_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.inBus    = inbus_q;
    assign bus.startAR4 = start_q;
    assign bus.getA     = geta_q;
    assign bus.getX     = getx_q;
    assign bus.putOut   = put_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ar4_host_sequencer.sv
// Bench for ar4_host_sequencer: three instances (defaults, short timeout,
// one-byte operands with long strobes) checked cycle by cycle against a
// trace built from the phase rules, plus table vectors and reset corners.
module tb_ar4_host_sequencer;

    typedef struct packed {
        logic [7:0] inbus;
        logic       start_n;
        logic       geta_n;
        logic       getx_n;
        logic       put_n;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct {
        int         sel;
        logic [15:0] a;
        logic [15:0] x;
        int         drop;
        int         rise;
        int         go_mid;
        int         fin;
        logic       err;
        int         puts;
    } vec_t;

    localparam int PL [3] = '{1, 1, 3};
    localparam int GL [3] = '{1, 1, 2};
    localparam int BL [3] = '{2, 2, 1};
    localparam int TL [3] = '{1024, 8, 16};
    localparam int PUTL   = 10;
    localparam obs_t IDLE_OBS = {8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        go_r;
    logic [1:0]  sel_r;
    logic [15:0] opa_r, opx_r;
    logic        rdy_r;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];
    obs_t log_q[$];
    obs_t o0, o1, o2, obs_cur;

    always #5 clk = ~clk;

    ar4_host_sequencer_if #(.N(16)) if0 ();
    ar4_host_sequencer_if #(.N(16)) if1 ();
    ar4_host_sequencer_if #(.N(8))  if2 ();

    assign if0.go = go_r & (sel_r == 2'd0);
    assign if1.go = go_r & (sel_r == 2'd1);
    assign if2.go = go_r & (sel_r == 2'd2);
    assign if0.opA = opa_r;
    assign if0.opX = opx_r;
    assign if1.opA = opa_r;
    assign if1.opX = opx_r;
    assign if2.opA = opa_r[7:0];
    assign if2.opX = opx_r[7:0];
    assign if0.readyAR4 = rdy_r;
    assign if1.readyAR4 = rdy_r;
    assign if2.readyAR4 = rdy_r;

    assign o0 = {if0.inBus, if0.startAR4, if0.getA, if0.getX, if0.putOut, if0.busy, if0.done, if0.err};
    assign o1 = {if1.inBus, if1.startAR4, if1.getA, if1.getX, if1.putOut, if1.busy, if1.done, if1.err};
    assign o2 = {if2.inBus, if2.startAR4, if2.getA, if2.getX, if2.putOut, if2.busy, if2.done, if2.err};

    always_comb begin
        case (sel_r)
            2'd1:    obs_cur = o1;
            2'd2:    obs_cur = o2;
            default: obs_cur = o0;
        endcase
    end

    ar4_host_sequencer #(.N(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
    ar4_host_sequencer #(.N(16), .TIMEOUT(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
    ar4_host_sequencer #(.N(8), .PULSE_LEN(3), .GAP_LEN(2), .TIMEOUT(16)) u2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic check_obs(input string nm, input int idx, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got=%h exp=%h", nm, idx, got, exp);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Ready level during wait-phase cycle t (t=0 is the first WAIT_LOW cycle).
    function automatic logic rdy_at(input int t, input int drop, input int rise);
        return !(t >= drop && t < rise);
    endfunction

    function automatic int load_len(input int s);
        return (PL[s] + GL[s]) + 2 * BL[s] * (1 + PL[s] + GL[s]);
    endfunction

    // Expected output trace from go acceptance through the done cycle.
    function automatic void build(input int s, input logic [15:0] a, input logic [15:0] x,
                                  input int drop, input int rise, output int fin, output logic e);
        obs_t o;
        logic [15:0] opnd;
        int wl, wh;
        logic found;
        exp_q.delete();
        e = 1'b0;
        o = IDLE_OBS;
        o.busy = 1'b1;
        o.start_n = 1'b0;
        repeat (PL[s]) exp_q.push_back(o);
        o.start_n = 1'b1;
        repeat (GL[s]) exp_q.push_back(o);
        for (int k = 0; k < 2; k++) begin
            opnd = (k == 0) ? a : x;
            for (int b = 0; b < BL[s]; b++) begin
                o.inbus = opnd[b*8 +: 8];
                exp_q.push_back(o);
                if (k == 0) o.geta_n = 1'b0; else o.getx_n = 1'b0;
                repeat (PL[s]) exp_q.push_back(o);
                o.geta_n = 1'b1;
                o.getx_n = 1'b1;
                repeat (GL[s]) exp_q.push_back(o);
            end
        end
        found = 1'b0;
        wl = TL[s];
        for (int j = 1; j <= TL[s]; j++) begin
            if (!found && !rdy_at(j - 1, drop, rise)) begin found = 1'b1; wl = j; end
        end
        if (!found) e = 1'b1;
        repeat (wl) exp_q.push_back(o);
        if (!e) begin
            found = 1'b0;
            wh = TL[s];
            for (int j = 1; j <= TL[s]; j++) begin
                if (!found && rdy_at(wl + j - 1, drop, rise)) begin found = 1'b1; wh = j; end
            end
            if (!found) e = 1'b1;
            repeat (wh) exp_q.push_back(o);
        end
        if (!e) begin
            o.put_n = 1'b0;
            repeat (PUTL) exp_q.push_back(o);
            o.put_n = 1'b1;
        end
        fin = exp_q.size();
        o.done = 1'b1;
        o.err = e;
        o.inbus = 8'h00;
        exp_q.push_back(o);
    endfunction

    // One transaction, entered and left #1 after a rising edge in IDLE.
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] x,
                          input int drop, input int rise, input int go_mid,
                          output int fin_seen, output logic err_seen, output int puts);
        int fin;
        logic e;
        int ll;
        build(s, a, x, drop, rise, fin, e);
        ll = load_len(s);
        log_q.delete();
        sel_r = 2'(s);
        opa_r = a;
        opx_r = x;
        rdy_r = 1'b1;
        go_r = 1'b1;
        @(negedge clk);
        check_obs("idle", s, obs_cur, IDLE_OBS);
        @(posedge clk);
        #1;
        go_r = 1'b0;
        fin_seen = -1;
        err_seen = 1'b0;
        puts = 0;
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c < ll) rdy_r = 1'($urandom_range(0, 1));
            else        rdy_r = rdy_at(c - ll, drop, rise);
            if (c == go_mid) begin
                go_r = 1'b1;
                opa_r = ~a;
                opx_r = ~x;
            end else begin
                go_r = 1'b0;
            end
            @(negedge clk);
            check_obs("trace", c, obs_cur, exp_q[c]);
            log_q.push_back(obs_cur);
            if (!obs_cur.put_n) puts++;
            if (obs_cur.done && fin_seen < 0) begin
                fin_seen = c;
                err_seen = obs_cur.err;
            end
            @(posedge clk);
            #1;
        end
        go_r = 1'b0;
        rdy_r = 1'b1;
        check_val("fin_model", fin_seen, fin);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int fs, pc, bad;
        logic es;

        tbl[0] = '{0, 16'hFFCA, 16'hFFE6, 3,    20,   5,  45, 1'b0, 10};
        tbl[1] = '{0, 16'h1234, 16'hA55A, 0,    1,   -1,  26, 1'b0, 10};
        tbl[2] = '{1, 16'h0F0F, 16'hF0F0, 1000, 1000, 3,  22, 1'b1, 0};
        tbl[3] = '{1, 16'h8001, 16'h7FFE, 7,    9,   -1,  34, 1'b0, 10};
        tbl[4] = '{1, 16'h00FF, 16'hFF00, 8,    20,  10,  22, 1'b1, 0};
        tbl[5] = '{1, 16'hBEEF, 16'hCAFE, 0,    1000, -1, 23, 1'b1, 0};
        tbl[6] = '{2, 16'h00C3, 16'h005A, 0,    1,    4,  29, 1'b0, 10};
        tbl[7] = '{2, 16'h0011, 16'h00EE, 2,    5,   -1,  33, 1'b0, 10};

        rst = 1'b1;
        go_r = 1'b0;
        sel_r = 2'd0;
        opa_r = 16'h0000;
        opx_r = 16'h0000;
        rdy_r = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_obs("reset0", 0, o0, IDLE_OBS);
        check_obs("reset1", 1, o1, IDLE_OBS);
        check_obs("reset2", 2, o2, IDLE_OBS);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].sel, tbl[i].a, tbl[i].x, tbl[i].drop, tbl[i].rise, tbl[i].go_mid, fs, es, pc);
            check_val("tbl_fin", fs, tbl[i].fin);
            check_val("tbl_err", int'(es), int'(tbl[i].err));
            check_val("tbl_put", pc, tbl[i].puts);
            if (i == 0) begin
                check_val("byte_a0", int'({log_q[3].geta_n, log_q[3].inbus}), int'({1'b0, 8'hCA}));
                check_val("byte_a1", int'({log_q[6].geta_n, log_q[6].inbus}), int'({1'b0, 8'hFF}));
                check_val("byte_x0", int'({log_q[9].getx_n, log_q[9].inbus}), int'({1'b0, 8'hE6}));
                check_val("byte_x1", int'({log_q[12].getx_n, log_q[12].inbus}), int'({1'b0, 8'hFF}));
            end
        end

        // Reset in the middle of the second getA pulse, with go held high.
        sel_r = 2'd0;
        opa_r = 16'h1234;
        opx_r = 16'h5678;
        go_r = 1'b1;
        @(posedge clk);
        #1;
        go_r = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_pre", int'({o0.geta_n, o0.inbus}), int'({1'b0, 8'h12}));
        #2;
        rst = 1'b1;
        go_r = 1'b1;
        #1;
        check_obs("rst_async", 0, o0, IDLE_OBS);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        go_r = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o0.done || o0.busy) bad++;
        end
        check_val("rst_quiet", bad, 0);
        @(posedge clk);
        #1;
        run_op(0, 16'h5AA5, 16'h0FF0, 1, 4, -1, fs, es, pc);

        // Randomized transactions against the trace model.
        for (int i = 0; i < 12; i++) begin
            int s, d;
            s = int'($urandom_range(0, 2));
            d = int'($urandom_range(0, 12));
            run_op(s, 16'($urandom), 16'($urandom), d, d + int'($urandom_range(1, 12)),
                   int'($urandom_range(0, 10)), fs, es, pc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ar4_host_sequencer.md
# ar4_host_sequencer

Host-side driver for the radix-4 multiplier's byte-bus loading interface. It accepts two N-bit operands in one request and issues the start strobe. It then streams both operands LSB-byte-first over the 8-bit bus with active-low load strobes, waits for the multiplier's ready handshake, and pulses the display-output strobe. It replaces manual pushbutton/switch operation, so a multiplication can be launched from on-chip logic.

## Interface
- N, 16: operand width; a multiple of 8, minimum 8; B = N/8 bytes per operand.
- PULSE_LEN, 1: strobe low time in cycles, minimum 1.
- GAP_LEN, 1: strobe high recovery time in cycles after each pulse, minimum 1.
- PUT_LEN, 10: putOut low time in cycles, minimum 1.
- TIMEOUT, 1024: maximum number of cycles to wait in each ready phase.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  request pulse; sampled only in IDLE.
- opA  in  N  multiplicand; captured on go acceptance.
- opX  in  N  multiplier; captured on go acceptance.
- readyAR4  in  1  multiplier ready level; synchronous to clk.
- inBus  out  8  byte bus to the multiplier; resets to 8'h00.
- startAR4  out  1  active-low start strobe; resets to 1.
- getA  out  1  active-low operand-A byte strobe; resets to 1.
- getX  out  1  active-low operand-X byte strobe; resets to 1.
- putOut  out  1  active-low display-output strobe; resets to 1.
- busy  out  1  high in every state except IDLE; resets to 0.
- done  out  1  one-cycle completion pulse; resets to 0.
- err  out  1  timeout flag; valid while done=1; otherwise 0; resets to 0.

## Operation
- States: IDLE, START, S_GAP, A_SETUP, A_PULSE, A_GAP, X_SETUP, X_PULSE, X_GAP, WAIT_LOW, WAIT_HIGH, PUT, FIN.
- IDLE:
  - When go=1, opA and opX are copied into shadow registers, the byte index is cleared, and the state moves to START.
  - go is ignored while busy=1.
- START: startAR4=0 for PULSE_LEN cycles, then S_GAP for GAP_LEN cycles.
- Per byte i = 0..B-1 of A:
  - A_SETUP (1 cycle): inBus = A[8i+7:8i], strobe high.
  - A_PULSE (PULSE_LEN cycles): getA=0.
  - A_GAP (GAP_LEN cycles): getA=1, data held.
  - After the last byte, the sequence moves to X. X uses the same sequence with getX.
- inBus is stable from SETUP through the end of GAP. Outside the byte phases it holds its last value; it returns to 8'h00 in FIN.
- At most one strobe is low in any cycle.
- WAIT_LOW: waits for readyAR4=0, which confirms the multiplier has begun computing.
- WAIT_HIGH: waits for readyAR4=1.
- Timeout:
  - Each wait state has its own counter, cleared on entry.
  - If TIMEOUT cycles pass without the awaited level, the state moves to FIN with err=1 and PUT is skipped.
- PUT: putOut=0 for PUT_LEN cycles.
- FIN (1 cycle): done=1 and err is valid; then the state moves to IDLE, where busy=0.
- Reset mid-operation: all strobes go high and inBus goes to 0 immediately. The state returns to IDLE and the shadow registers are cleared. No done is issued.

## Timing
- busy rises in the cycle after the go sample.
- Cycles from go acceptance to WAIT_LOW entry: (PULSE_LEN+GAP_LEN) + 2·B·(1+PULSE_LEN+GAP_LEN). With defaults this is 2 + 4·3 = 14.
- readyAR4 is sampled at the end of each wait cycle. The earliest exit is 1 cycle per wait state.
- After WAIT_HIGH is satisfied, PUT lasts PUT_LEN cycles, then FIN lasts 1 cycle.
- Minimum error-free total with defaults: 14 + 1 + 1 + 10 + 1 = 27 cycles.
- Back-to-back operation: go may be accepted in the cycle after FIN, i.e. the first IDLE cycle.
- Simultaneous events:
  - go together with rst: reset wins.
  - readyAR4 toggling during the load states is ignored.

## Structure
- ar4_host_pkg:
  - state enum
  - BYTE_W=8 constant
  - function for the B = N/8 byte count
- Sub-module ar4_strobe_timer:
  - loadable down-counter with a terminal-count flag
  - shared by pulse, gap, PUT and timeout timing (one instance, reloaded on each state entry).
- Top level: FSM, shadow registers, byte index counter, and registered outputs (no combinational paths from inputs to outputs).

## Test plan
- Byte order: opA=16'hFFCA, opX=16'hFFE6, defaults → startAR4 pulses once. inBus shows CA then FF under getA=0, then E6 then FF under getX=0, each pulse 1 cycle with 1-cycle setup and gap.
- Handshake: readyAR4 drops 3 cycles and rises 20 cycles after WAIT_LOW entry → putOut=0 for exactly 10 cycles, then done=1 with err=0.
- Timeout: TIMEOUT=8 and readyAR4 held at 1 → done and err both assert 8 cycles after WAIT_LOW entry, and putOut never goes low.
- Reset mid-load: rst asserted during the second getA pulse → getA=1 and inBus=0 within the same cycle, busy=0, no done; a following go restarts cleanly from START.
- Ignored go: go pulsed while busy → no effect; a second go in the first IDLE cycle after FIN is accepted.
- Parameters: N=8, PULSE_LEN=3, GAP_LEN=2 → exactly one byte per operand, each strobe low for 3 cycles; WAIT_LOW entry 5 + 2·6 = 17 cycles after go acceptance.
